// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the fetch stage and its hold buffer.
//   NOP_INSTR     - instruction word used for pipeline bubbles
//   fetch_state_t - fetch FSM states
//   IF_ID_t       - contents of the IF/ID pipeline register
//   IF_ID_BUBBLE  - IF_ID_t value representing an empty slot
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus_4;
        logic        interrupt;
        logic        valid;
    } IF_ID_t;

    localparam IF_ID_t IF_ID_BUBBLE = '{
        instr:     NOP_INSTR,
        pc_plus_4: 32'h0000_0000,
        interrupt: 1'b0,
        valid:     1'b0
    };

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry IF/ID buffer that parks a word returned while the
// pipe is stalled.
//   clk, rst_n  - clock, synchronous active-low reset (empties the buffer)
//   load_i      - capture data_i
//   drain_i     - entry consumed; buffer becomes a bubble
//   clear_i     - discard the entry (redirect); wins over load_i
//   data_i      - entry to capture
//   data_o      - current entry
module fetch_hold_buf
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   drain_i,
    input  logic   clear_i,
    input  IF_ID_t data_i,
    output IF_ID_t data_o
);

    IF_ID_t buf_q;
    IF_ID_t buf_d;

    always_comb begin
        buf_d = buf_q;
        if (clear_i) begin
            buf_d = IF_ID_BUBBLE;
        end else if (load_i) begin
            buf_d = data_i;
        end else if (drain_i) begin
            buf_d = IF_ID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= IF_ID_BUBBLE;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign data_o = buf_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-memory request/ack handshake,
// branch redirect, interrupt entry and the IF/ID pipeline register.
//   clk, rst_n            - clock, synchronous active-low reset
//   stall                 - freeze PC and IF/ID (flush still bubbles IF/ID)
//   flush                 - bubble into IF/ID at the next edge
//   branch_sel, branch_pc - redirect from decode
//   int_req, returni      - interrupt request level, return-from-interrupt
//   imem_req, imem_addr   - fetch request and word address (combinational)
//   imem_ack, imem_rdata  - memory acknowledge and instruction word
//   instr, pc_plus_4, interrupt, valid - registered IF/ID outputs
//
//   state | meaning
//   ------+---------------------------------------------------------
//   FETCH | requesting the word at pc
//   HOLD  | word returned during a stall is parked in the hold buffer
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_sel,
    input  logic [31:0] branch_pc,
    input  logic        int_req,
    input  logic        returni,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_plus_4,
    output logic        interrupt,
    output logic        valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ret_pc_q, ret_pc_d;
    logic         int_en_q, int_en_d;
    // Set on interrupt entry; marks the next accepted word as the handler's first.
    logic         tag_q, tag_d;
    IF_ID_t       if_id_q, if_id_d;

    IF_ID_t       ack_entry;
    IF_ID_t       hb_data;
    logic         hb_load, hb_drain, hb_clear;
    logic         boundary;
    logic         int_take;
    logic [31:0]  next_pc;
    logic [31:0]  pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        ack_entry.instr     = imem_rdata;
        ack_entry.pc_plus_4 = tag_q ? ret_pc_q : pc_inc;
        ack_entry.interrupt = tag_q;
        ack_entry.valid     = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ret_pc_d = ret_pc_q;
        int_en_d = int_en_q;
        tag_d    = tag_q;
        if_id_d  = if_id_q;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        hb_clear = 1'b0;
        boundary = 1'b0;
        int_take = 1'b0;
        next_pc  = pc_q;

        if (stall) begin
            // The returned word is still accepted so it is never re-fetched.
            if (state_q == FETCH && imem_ack) begin
                hb_load = 1'b1;
                pc_d    = pc_inc;
                tag_d   = 1'b0;
                state_d = HOLD;
            end
        end else if (branch_sel) begin
            pc_d     = branch_pc;
            if_id_d  = IF_ID_BUBBLE;
            hb_clear = 1'b1;
            tag_d    = 1'b0;
            state_d  = FETCH;
        end else begin
            if (state_q == HOLD) begin
                // pc already points past the held word.
                if_id_d  = hb_data;
                hb_drain = 1'b1;
                state_d  = FETCH;
                boundary = 1'b1;
                next_pc  = pc_q;
            end else if (imem_ack) begin
                if_id_d  = ack_entry;
                tag_d    = 1'b0;
                boundary = 1'b1;
                next_pc  = pc_inc;
                pc_d     = pc_inc;
            end else begin
                if_id_d = IF_ID_BUBBLE;
            end

            if (boundary && int_req && int_en_q) begin
                pc_d     = INT_VECTOR;
                ret_pc_d = next_pc;
                int_en_d = 1'b0;
                tag_d    = 1'b1;
                int_take = 1'b1;
            end
        end

        if (returni && !int_take) begin
            int_en_d = 1'b1;
        end

        if (flush) begin
            if_id_d = IF_ID_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ret_pc_q <= 32'h0000_0000;
            int_en_q <= 1'b1;
            tag_q    <= 1'b0;
            if_id_q  <= IF_ID_BUBBLE;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ret_pc_q <= ret_pc_d;
            int_en_q <= int_en_d;
            tag_q    <= tag_d;
            if_id_q  <= if_id_d;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hb_load),
        .drain_i (hb_drain),
        .clear_i (hb_clear),
        .data_i  (ack_entry),
        .data_o  (hb_data)
    );

    // No request while reset is asserted.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;

    assign instr     = if_id_q.instr;
    assign pc_plus_4 = if_id_q.pc_plus_4;
    assign interrupt = if_id_q.interrupt;
    assign valid     = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] VEC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, branch_sel, int_req, returni, imem_ack;
    logic [31:0] branch_pc;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr, pc_plus_4;
    logic        interrupt, valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0019_660D) + 32'h3C6E_F35F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(32'h0), .INT_VECTOR(VEC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_sel(branch_sel), .branch_pc(branch_pc),
        .int_req(int_req), .returni(returni),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc_plus_4(pc_plus_4),
        .interrupt(interrupt), .valid(valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_sel = 0; branch_pc = 0;
        int_req = 0; returni = 0; imem_ack = 0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("reset imem_req", {31'b0, imem_req}, 32'd0);
        edge_step();
        edge_step();
        chk("reset valid", {31'b0, valid}, 32'd0);
        chk("reset instr", instr, NOP_INSTR);
        chk("reset pc_plus_4", pc_plus_4, 32'd0);
        chk("reset interrupt", {31'b0, interrupt}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-reset imem_addr", imem_addr, 32'h0);
    endtask

    typedef struct {
        logic        s, f, b;
        logic [31:0] bpc;
        logic        irq, rti, ack;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] eppc, esrc;
        logic        eint;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, f, b, input logic [31:0] bpc,
                       input logic irq, rti, ack, ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] eppc, esrc, input logic eint);
        vec_t v;
        v = '{s:s, f:f, b:b, bpc:bpc, irq:irq, rti:rti, ack:ack, ereq:ereq,
              eaddr:eaddr, ev:ev, eppc:eppc, esrc:esrc, eint:eint};
        tbl.push_back(v);
    endtask

    // Reference model state: queue of accepted-but-undelivered words.
    IF_ID_t      m_q[$];
    IF_ID_t      m_out, m_entry;
    logic [31:0] m_pc, m_ret, r;
    bit          m_int_en, m_tag, m_hold, m_accept, m_bound, m_take;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        //  s f b bpc           irq rti ack req addr          v ppc4          src           int
        add(0,0,0,0,            0,0,1, 1,32'h0,          1,32'h4,        32'h0,        0);
        add(0,0,0,0,            0,0,1, 1,32'h4,          1,32'h8,        32'h4,        0);
        add(0,0,0,0,            0,0,0, 1,32'h8,          0,0,            0,            0);
        add(0,0,0,0,            0,0,0, 1,32'h8,          0,0,            0,            0);
        add(0,0,0,0,            0,0,1, 1,32'h8,          1,32'hC,        32'h8,        0);
        add(1,0,0,0,            0,0,1, 1,32'hC,          1,32'hC,        32'h8,        0);
        add(1,0,0,0,            0,0,0, 0,0,              1,32'hC,        32'h8,        0);
        add(1,0,0,0,            0,0,0, 0,0,              1,32'hC,        32'h8,        0);
        add(0,0,0,0,            0,0,0, 0,0,              1,32'h10,       32'hC,        0);
        add(0,0,1,32'h200,      0,0,1, 1,32'h10,         0,0,            0,            0);
        add(0,0,0,0,            0,0,1, 1,32'h200,        1,32'h204,      32'h200,      0);
        add(0,0,0,0,            0,0,1, 1,32'h204,        1,32'h208,      32'h204,      0);
        add(0,0,1,32'h1C,       0,0,0, 1,32'h208,        0,0,            0,            0);
        add(0,0,0,0,            0,0,1, 1,32'h1C,         1,32'h20,       32'h1C,       0);
        add(0,0,0,0,            1,0,1, 1,32'h20,         1,32'h24,       32'h20,       0);
        add(0,0,0,0,            1,0,1, 1,VEC,            1,32'h24,       VEC,          1);
        add(0,0,0,0,            1,0,1, 1,32'h1004,       1,32'h1008,     32'h1004,     0);
        add(0,0,0,0,            1,1,1, 1,32'h1008,       1,32'h100C,     32'h1008,     0);
        add(0,0,0,0,            1,0,1, 1,32'h100C,       1,32'h1010,     32'h100C,     0);
        add(0,0,0,0,            0,0,1, 1,VEC,            1,32'h1010,     VEC,          1);
        add(0,0,0,0,            0,1,1, 1,32'h1004,       1,32'h1008,     32'h1004,     0);
        add(0,0,0,0,            1,1,1, 1,32'h1008,       1,32'h100C,     32'h1008,     0);
        add(0,0,0,0,            1,0,1, 1,VEC,            1,32'h100C,     VEC,          1);
        add(0,0,0,0,            1,0,1, 1,32'h1004,       1,32'h1008,     32'h1004,     0);
        add(0,1,0,0,            0,0,1, 1,32'h1008,       0,0,            0,            0);
        add(0,0,0,0,            0,0,1, 1,32'h100C,       1,32'h1010,     32'h100C,     0);
        add(1,1,0,0,            0,0,1, 1,32'h1010,       0,0,            0,            0);
        add(0,0,0,0,            0,0,0, 0,0,              1,32'h1014,     32'h1010,     0);
        add(0,0,0,0,            0,0,1, 1,32'h1014,       1,32'h1018,     32'h1014,     0);
        add(0,0,1,32'hFFFF_FFFC,0,0,0, 1,32'h1018,       0,0,            0,            0);
        add(0,0,0,0,            0,0,1, 1,32'hFFFF_FFFC,  1,32'h0,        32'hFFFF_FFFC,0);
        add(0,0,0,0,            0,0,1, 1,32'h0,          1,32'h4,        32'h0,        0);

        // ---- directed table ----
        do_reset();
        foreach (tbl[i]) begin
            stall = tbl[i].s; flush = tbl[i].f; branch_sel = tbl[i].b;
            branch_pc = tbl[i].bpc; int_req = tbl[i].irq; returni = tbl[i].rti;
            imem_ack = tbl[i].ack;
            #1;
            chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].ereq});
            if (tbl[i].ereq)
                chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].eaddr);
            edge_step();
            chk($sformatf("row%0d valid", i), {31'b0, valid}, {31'b0, tbl[i].ev});
            chk($sformatf("row%0d pc_plus_4", i), pc_plus_4, tbl[i].eppc);
            chk($sformatf("row%0d interrupt", i), {31'b0, interrupt}, {31'b0, tbl[i].eint});
            chk($sformatf("row%0d instr", i), instr,
                tbl[i].ev ? mem_word(tbl[i].esrc) : NOP_INSTR);
        end

        // ---- reset while a word is held ----
        do_reset();
        stall = 1; imem_ack = 1;
        #1;
        chk("hold-rst req before ack", {31'b0, imem_req}, 32'd1);
        edge_step();
        imem_ack = 0;
        #1;
        chk("hold-rst in HOLD req", {31'b0, imem_req}, 32'd0);
        edge_step();
        rst_n = 0; stall = 0;
        #1;
        chk("hold-rst reset-cycle req", {31'b0, imem_req}, 32'd0);
        edge_step();
        rst_n = 1;
        #1;
        chk("hold-rst valid", {31'b0, valid}, 32'd0);
        chk("hold-rst req", {31'b0, imem_req}, 32'd1);
        chk("hold-rst addr", imem_addr, 32'h0);
        for (int k = 0; k < 2; k++) begin
            edge_step();
            chk($sformatf("hold-rst no emit %0d", k), {31'b0, valid}, 32'd0);
        end
        imem_ack = 1;
        edge_step();
        chk("hold-rst refetch ppc4", pc_plus_4, 32'h4);
        chk("hold-rst refetch valid", {31'b0, valid}, 32'd1);
        chk("hold-rst refetch instr", instr, mem_word(32'h0));

        // ---- randomized run against the stream model ----
        do_reset();
        m_q.delete();
        m_pc = 32'h0; m_ret = 32'h0; m_int_en = 1; m_tag = 0;
        m_out = IF_ID_BUBBLE;
        for (int c = 0; c < 400; c++) begin
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            branch_sel = ($urandom_range(0, 11) == 0);
            r = $urandom();
            branch_pc  = r & 32'h0000_FFFC;
            int_req    = ($urandom_range(0, 5) == 0);
            returni    = ($urandom_range(0, 9) == 0);
            imem_ack   = ($urandom_range(0, 2) != 0);
            #1;
            m_hold = (m_q.size() != 0);
            chk($sformatf("rnd%0d imem_req", c), {31'b0, imem_req}, {31'b0, !m_hold});
            if (!m_hold)
                chk($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);

            m_accept = !m_hold && imem_ack;
            m_entry.instr     = mem_word(m_pc);
            m_entry.pc_plus_4 = m_tag ? m_ret : m_pc + 32'd4;
            m_entry.interrupt = m_tag;
            m_entry.valid     = 1'b1;
            m_take = 0;
            if (stall) begin
                if (m_accept) begin
                    m_q.push_back(m_entry);
                    m_pc = m_pc + 32'd4;
                    m_tag = 0;
                end
            end else if (branch_sel) begin
                m_q.delete();
                m_pc = branch_pc;
                m_tag = 0;
                m_out = IF_ID_BUBBLE;
            end else begin
                m_bound = m_hold || m_accept;
                if (m_hold) begin
                    m_out = m_q.pop_front();
                end else if (m_accept) begin
                    m_out = m_entry;
                    m_pc = m_pc + 32'd4;
                    m_tag = 0;
                end else begin
                    m_out = IF_ID_BUBBLE;
                end
                if (m_bound && int_req && m_int_en) begin
                    m_ret = m_pc;
                    m_pc = VEC;
                    m_int_en = 0;
                    m_tag = 1;
                    m_take = 1;
                end
            end
            if (returni && !m_take) m_int_en = 1;
            if (flush) m_out = IF_ID_BUBBLE;

            edge_step();
            chk($sformatf("rnd%0d valid", c), {31'b0, valid}, {31'b0, m_out.valid});
            chk($sformatf("rnd%0d instr", c), instr, m_out.instr);
            chk($sformatf("rnd%0d pc_plus_4", c), pc_plus_4, m_out.pc_plus_4);
            chk($sformatf("rnd%0d interrupt", c), {31'b0, interrupt}, {31'b0, m_out.interrupt});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It owns the program counter and drives a read-only instruction memory through a level request/acknowledge handshake. It applies decode-stage branch redirects and external interrupt entry, then presents `instr`, `pc_plus_4` and `interrupt` to decode. A hold buffer absorbs instructions returned while the pipe is stalled, so no fetched word is lost or re-fetched.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded at reset.
- `INT_VECTOR`, 32'h0000_1000: fetch address on interrupt entry.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `stall`, input, 1: hazard hold; freezes the IF/ID register and PC.
- `flush`, input, 1: loads a bubble into IF/ID at the next edge.
- `branch_sel`, input, 1: redirect request from decode.
- `branch_pc`, input, 32: redirect target from decode.
- `int_req`, input, 1: external interrupt, level.
- `returni`, input, 1: return-from-interrupt executed; re-enables interrupts.
- `imem_req`, output, 1: fetch address valid.
- `imem_addr`, output, 32: fetch address, word aligned.
- `imem_ack`, input, 1: `imem_rdata` valid for the current `imem_addr`.
- `imem_rdata`, input, 32: instruction word.
- `instr`, output, 32: IF/ID instruction.
- `pc_plus_4`, output, 32: IF/ID PC+4, or the return PC when tagged.
- `interrupt`, output, 1: IF/ID instruction is the first interrupt-handler instruction.
- `valid`, output, 1: IF/ID holds a real instruction.

## Operation
- **State machine**, states `FETCH` and `HOLD`.
  - `FETCH`: `imem_req`=1, `imem_addr`=`pc`.
  - `HOLD`: `imem_req`=0; a fetched word waits in the hold buffer.
- **Memory handshake.** `imem_ack` may arrive in the request cycle (combinational memory) or any later cycle. `imem_addr` stays stable until ack, except on redirect. The memory is side-effect free, so abandoning a request is legal.
- **Next-PC priority per edge**, highest first:
  1. `rst_n`=0.
  2. `stall`=1: hold PC; `branch_sel` is ignored.
  3. `branch_sel`: `pc`←`branch_pc`; IF/ID←bubble; any ack this cycle and any held word are discarded; state→`FETCH`.
  4. Interrupt entry: condition is `int_req` && `int_en` at an instruction boundary (ack, or leaving `HOLD`). Effects: `pc`←`INT_VECTOR`; `ret_pc` latches the PC that would have been fetched next; `int_en`←0. The first word fetched from the vector is tagged `interrupt`=1 with `pc_plus_4`=`ret_pc`.
  5. Sequential: on ack, `pc`←`pc`+4 (mod 2^32, wrap silently).
- **`FETCH` with ack and `stall`=0:** IF/ID←{`imem_rdata`, `pc`+4, `valid`=1}; stay in `FETCH`.
- **`FETCH` with ack and `stall`=1:** word goes into the hold buffer; `pc` advances; state→`HOLD`.
- **`HOLD` with `stall`=0:** IF/ID←hold buffer; state→`FETCH`.
- **Flush:** `flush`=1 forces IF/ID to bubble ({`NOP_INSTR`, 0, `interrupt`=0, `valid`=0}), overriding `stall` for IF/ID only. The PC and hold buffer are unaffected unless `branch_sel` is also set.
- **`int_en`:** set by `returni`. If `returni` and interrupt entry fall in the same cycle, entry wins and `int_en` ends at 0.
- **Reset values:** `pc`=`RESET_PC`, state=`FETCH`, `instr`=`NOP_INSTR`, `pc_plus_4`=0, `interrupt`=0, `valid`=0, `int_en`=1, `imem_req`=0 in the reset cycle.
- **Reset mid-operation:** the outstanding fetch and held word are dropped and the PC restarts at `RESET_PC`.

## Timing
- **Latency:** 1 cycle, from the ack edge to the IF/ID output.
- **Throughput:** one instruction per cycle with zero-wait memory.
- **Redirect:** the target address is on `imem_addr` the cycle after the `branch_sel` edge. Penalty is 1 bubble; there is no delay slot.
- **Stall-in-`FETCH` case:** `imem_req` drops the cycle after the ack that lands in `HOLD`.
- **Resuming from `HOLD`:** the held word appears on IF/ID one edge after `stall` falls, and fetch resumes in that same cycle.
- All outputs are registered except `imem_req` and `imem_addr`, which decode from state and `pc`.

## Structure
- **Shared package `cpu_pkg`:** `NOP_INSTR` (32'h0000_0000), `fetch_state_t` enum {`FETCH`, `HOLD`}, and `IF_ID_t` packed struct {`instr`, `pc_plus_4`, `interrupt`, `valid`}.
- **Sub-module `fetch_hold_buf`:** a one-entry `IF_ID_t` buffer with load, drain and clear inputs.
- The remaining PC and next-PC logic and the FSM stay in `fetch_stage`.

## Test plan
- **Zero-wait sequential fetch:** reset with `RESET_PC`=0, ack every cycle, then 4 cycles. Required: `imem_addr` 0, 4, 8, 12; IF/ID `pc_plus_4` 4, 8, 12, 16 on consecutive cycles with `valid`=1.
- **Wait states:** ack delayed 2 cycles at address 8. Required: `imem_addr` held at 8 for 3 cycles, one instruction out, no duplicate.
- **Stall:** `stall`=1 for 3 cycles when ack arrives at address 12. Required: state `HOLD`, `imem_req`=0, IF/ID frozen; after release the word from address 12 appears, then address 16 is fetched.
- **Branch redirect:** `branch_sel`=1, `branch_pc`=0x200 while the fetch at 0x10 is acked. Required: next `imem_addr`=0x200, one bubble, the word from 0x10 never reaches IF/ID.
- **Interrupt entry:** `int_req`=1 at the boundary before fetching 0x24. Required: `imem_addr`=0x1000; IF/ID `interrupt`=1 with `pc_plus_4`=0x24; a second `int_req` is ignored until `returni` is pulsed.
- **Reset during `HOLD`:** reset asserted while a word is held. Required: after reset, `valid`=0, `imem_addr`=`RESET_PC`, the held word is never emitted.
